btn_events: RTL and testbench

Turns per-button debounced levels into a stream of discrete events: PRESS, RELEASE, LONG (held past a threshold) and REPEAT (auto-repeat while held). Events are queued in a small FIFO behind a valid/ready port. It sits between the debouncer instances on the board buttons and the UI or command logic. That logic then consumes one event at a time instead of polling levels and running its own timers.

---
 rtl/btn_events.sv | 219 +++++++++++++++++++++
 tb/tb_btn_events.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_events.sv
// btn_events: converts debounced button levels into PRESS/RELEASE/LONG/REPEAT
// events. Events are arbitrated round-robin into a small FIFO that is read
// through a valid/ready port. A sticky overflow flag records dropped events.
module btn_events #(
  parameter int N            = 4,
  parameter int TICK_DIV     = 1000,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int FIFO_DEPTH   = 4,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   btn,
  output logic           ev_valid,
  input  logic           ev_ready,
  output logic [IDW-1:0] ev_id,
  output logic [1:0]     ev_kind,
  output logic           overflow
);

  localparam int TW   = $clog2(TICK_DIV);
  localparam int HMAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HCW  = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;

  localparam logic [1:0] K_PRESS   = 2'd0;
  localparam logic [1:0] K_RELEASE = 2'd1;
  localparam logic [1:0] K_LONG    = 2'd2;
  localparam logic [1:0] K_REPEAT  = 2'd3;

  typedef enum logic [1:0] {IDLE, DOWN, HELD} state_e;

  logic [N-1:0]   btn_q;
  logic [N-1:0]   rise;
  logic [N-1:0]   fall;
  logic [TW-1:0]  pre_cnt;
  logic           tick;
  state_e         state_q [N];
  state_e         state_d [N];
  logic [HCW-1:0] hc_q [N];
  logic [HCW-1:0] hc_d [N];
  logic [N-1:0]   req;
  logic [1:0]     req_kind [N];
  logic [N-1:0]   pend_v;
  logic [1:0]     pend_k [N];
  logic [IDW-1:0] last_grant;
  logic [N-1:0]   gnt;
  logic           push;
  logic [IDW-1:0] gnt_id;
  logic [1:0]     gnt_kind;
  logic [IDW-1:0] arb_idx;
  logic           pop;
  logic           push_ok;
  logic           drop;
  logic [IDW-1:0] fifo_id [FIFO_DEPTH];
  logic [1:0]     fifo_kind [FIFO_DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count;

  assign rise = btn & ~btn_q;
  assign fall = ~btn & btn_q;
  assign tick = (pre_cnt == TW'(TICK_DIV - 1));

  // Previous button levels for edge detection; cleared so a held button re-presses after reset.
  always_ff @(posedge clk) begin
    if (rst) btn_q <= '0;
    else     btn_q <= btn;
  end

  // Shared free-running prescaler producing one tick every TICK_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst)       pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  // Per-button state and hold-counter registers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        state_q[i] <= IDLE;
        hc_q[i]    <= '0;
      end else begin
        state_q[i] <= state_d[i];
        hc_q[i]    <= hc_d[i];
      end
    end
  end

  // Per-button next state and event requests; a release wins over a tick in the same cycle.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_d[i]  = state_q[i];
      hc_d[i]     = hc_q[i];
      req[i]      = 1'b0;
      req_kind[i] = K_PRESS;
      case (state_q[i])
        IDLE: begin
          if (rise[i]) begin
            state_d[i]  = DOWN;
            hc_d[i]     = '0;
            req[i]      = 1'b1;
            req_kind[i] = K_PRESS;
          end
        end
        DOWN: begin
          if (fall[i]) begin
            state_d[i]  = IDLE;
            req[i]      = 1'b1;
            req_kind[i] = K_RELEASE;
          end else if (tick) begin
            if (hc_q[i] == HCW'(LONG_TICKS - 1)) begin
              state_d[i]  = HELD;
              hc_d[i]     = '0;
              req[i]      = 1'b1;
              req_kind[i] = K_LONG;
            end else begin
              hc_d[i] = hc_q[i] + 1'b1;
            end
          end
        end
        HELD: begin
          if (fall[i]) begin
            state_d[i]  = IDLE;
            req[i]      = 1'b1;
            req_kind[i] = K_RELEASE;
          end else if (tick) begin
            if (hc_q[i] == HCW'(REPEAT_TICKS - 1)) begin
              hc_d[i]     = '0;
              req[i]      = 1'b1;
              req_kind[i] = K_REPEAT;
            end else begin
              hc_d[i] = hc_q[i] + 1'b1;
            end
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  assign pop     = ev_valid & ev_ready;
  assign push_ok = (count < CW'(FIFO_DEPTH)) || pop;
  assign drop    = |(req & pend_v & ~gnt);

  // Round-robin arbiter: first valid pending slot after the last granted button.
  always_comb begin
    gnt      = '0;
    push     = 1'b0;
    gnt_id   = '0;
    gnt_kind = K_PRESS;
    arb_idx  = '0;
    if (push_ok) begin
      for (int off = 0; off < N; off++) begin
        arb_idx = IDW'((int'(last_grant) + 1 + off) % N);
        if (!push && pend_v[arb_idx]) begin
          push         = 1'b1;
          gnt[arb_idx] = 1'b1;
          gnt_id       = arb_idx;
          gnt_kind     = pend_k[arb_idx];
        end
      end
    end
  end

  // Pending slots load when free or being granted; otherwise the request is lost and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < N; i++) pend_k[i] <= K_PRESS;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && (!pend_v[i] || gnt[i])) begin
          pend_v[i] <= 1'b1;
          pend_k[i] <= req_kind[i];
        end else if (gnt[i]) begin
          pend_v[i] <= 1'b0;
        end
      end
      if (drop) overflow <= 1'b1;
    end
  end

  // Remember the last granted button so the search rotates; reset favours button 0.
  always_ff @(posedge clk) begin
    if (rst)       last_grant <= IDW'(N - 1);
    else if (push) last_grant <= gnt_id;
  end

  // Event FIFO; when full, a simultaneous pop frees the slot the push overwrites.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_id[i]   <= '0;
        fifo_kind[i] <= K_PRESS;
      end
    end else begin
      if (push) begin
        fifo_id[wr_ptr]   <= gnt_id;
        fifo_kind[wr_ptr] <= gnt_kind;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
  end

  assign ev_valid = (count != '0);
  assign ev_id    = fifo_id[rd_ptr];
  assign ev_kind  = fifo_kind[rd_ptr];

endmodule

// File: tb/tb_btn_events.sv
// tb_btn_events: directed scenarios for btn_events with a queue of expected
// events that is compared against every event the consumer accepts.
module tb_btn_events;

  localparam logic [1:0] P = 2'd0;
  localparam logic [1:0] R = 2'd1;
  localparam logic [1:0] L = 2'd2;
  localparam logic [1:0] T = 2'd3;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_id;
  logic [1:0] ev_kind;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [3:0] sb [$];
  int pop_cyc [$];

  btn_events #(
    .N(4), .TICK_DIV(4), .LONG_TICKS(3), .REPEAT_TICKS(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_id(ev_id), .ev_kind(ev_kind), .overflow(overflow)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] b, input logic r);
    btn      = b;
    ev_ready = r;
  endtask

  task automatic expect_ev(input logic [1:0] id, input logic [1:0] kind);
    sb.push_back({id, kind});
  endtask

  task automatic consume();
    logic [3:0] exp_ev;
    if (sb.size() == 0) begin
      check_output("unexpected_event", 32'(ev_valid), 32'd0);
    end else begin
      exp_ev = sb.pop_front();
      check_output("event_id_kind", {28'd0, ev_id, ev_kind}, {28'd0, exp_ev});
      pop_cyc.push_back(cyc);
    end
  endtask

  task automatic cycle();
    if (ev_valid && ev_ready) consume();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || ev_valid) && n < 100) begin
      cycle();
      n++;
    end
    check_output("drain_valid_low", 32'(ev_valid), 32'd0);
    check_output("drain_sb_empty", sb.size(), 32'd0);
    cycles(4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  // Linear sequence of directed scenarios.
  initial begin
    rst = 1'b1;
    apply_stimulus(4'b0000, 1'b0);
    do_reset();
    check_output("reset_ev_valid", 32'(ev_valid), 32'd0);
    check_output("reset_ev_id", 32'(ev_id), 32'd0);
    check_output("reset_ev_kind", 32'(ev_kind), 32'd0);
    check_output("reset_overflow", 32'(overflow), 32'd0);

    // Short press on button 2: PRESS then RELEASE only, one-edge latency.
    $display("[TB] short press");
    apply_stimulus(4'b0100, 1'b1);
    expect_ev(2'd2, P);
    cycle();
    check_output("lat_edge_k_valid", 32'(ev_valid), 32'd0);
    cycle();
    check_output("lat_edge_k1_valid", 32'(ev_valid), 32'd1);
    check_output("lat_edge_k1_id", 32'(ev_id), 32'd2);
    check_output("lat_edge_k1_kind", 32'(ev_kind), 32'(P));
    cycles(4);
    apply_stimulus(4'b0000, 1'b1);
    expect_ev(2'd2, R);
    drain();
    check_output("short_overflow", 32'(overflow), 32'd0);

    // Long hold on button 1: PRESS, LONG, three REPEATs, RELEASE with exact gaps.
    $display("[TB] long hold");
    pop_cyc.delete();
    apply_stimulus(4'b0010, 1'b1);
    expect_ev(2'd1, P);
    expect_ev(2'd1, L);
    expect_ev(2'd1, T);
    expect_ev(2'd1, T);
    expect_ev(2'd1, T);
    cycles(40);
    apply_stimulus(4'b0000, 1'b1);
    expect_ev(2'd1, R);
    drain();
    check_output("hold_event_count", pop_cyc.size(), 32'd6);
    if (pop_cyc.size() == 6) begin
      check_output("long_gap_9_to_12",
                   32'((pop_cyc[1] - pop_cyc[0] >= 9) && (pop_cyc[1] - pop_cyc[0] <= 12)), 32'd1);
      for (int i = 2; i < 5; i++)
        check_output("repeat_gap", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd8);
      check_output("release_gap", 32'(pop_cyc[5] - pop_cyc[0]), 32'd40);
    end

    // All four buttons on one edge: round-robin order, consecutive delivery.
    $display("[TB] simultaneous presses");
    do_reset();
    pop_cyc.delete();
    apply_stimulus(4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) expect_ev(2'(i), P);
    cycles(6);
    apply_stimulus(4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) expect_ev(2'(i), R);
    drain();
    check_output("simul_event_count", pop_cyc.size(), 32'd8);
    if (pop_cyc.size() == 8) begin
      for (int i = 1; i < 4; i++)
        check_output("simul_press_gap", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);
      for (int i = 5; i < 8; i++)
        check_output("simul_release_gap", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);
    end
    apply_stimulus(4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) expect_ev(2'(i), P);
    cycles(6);
    apply_stimulus(4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) expect_ev(2'(i), R);
    drain();

    // Stalled consumer: FIFO fills, slots fill, later requests drop.
    $display("[TB] stalled consumer overflow");
    do_reset();
    for (int b = 0; b < 4; b++) begin
      apply_stimulus(4'(1 << b), 1'b0);
      expect_ev(2'(b), P);
      cycles(2);
      apply_stimulus(4'b0000, 1'b0);
      if (b < 2) expect_ev(2'(b), R);
      cycles(2);
    end
    cycles(2);
    check_output("stall_valid", 32'(ev_valid), 32'd1);
    check_output("stall_head_id", 32'(ev_id), 32'd0);
    check_output("stall_head_kind", 32'(ev_kind), 32'(P));
    check_output("stall_overflow", 32'(overflow), 32'd1);
    cycles(3);
    check_output("stall_head_id_stable", 32'(ev_id), 32'd0);
    check_output("stall_head_kind_stable", 32'(ev_kind), 32'(P));
    apply_stimulus(4'b0000, 1'b1);
    drain();
    check_output("overflow_sticky", 32'(overflow), 32'd1);

    // Full FIFO with a pending slot and a new press: push and pop together, nothing lost.
    $display("[TB] full fifo simultaneous push/pop");
    do_reset();
    pop_cyc.delete();
    for (int b = 0; b < 2; b++) begin
      apply_stimulus(4'(1 << b), 1'b0);
      expect_ev(2'(b), P);
      cycles(2);
      apply_stimulus(4'b0000, 1'b0);
      expect_ev(2'(b), R);
      cycles(2);
    end
    apply_stimulus(4'b0100, 1'b0);
    expect_ev(2'd2, P);
    cycle();
    apply_stimulus(4'b1100, 1'b1);
    expect_ev(2'd3, P);
    cycles(2);
    apply_stimulus(4'b0000, 1'b1);
    expect_ev(2'd2, R);
    expect_ev(2'd3, R);
    drain();
    check_output("full_overflow", 32'(overflow), 32'd0);
    check_output("full_event_count", pop_cyc.size(), 32'd8);
    if (pop_cyc.size() == 8) begin
      for (int i = 1; i < 8; i++)
        check_output("full_pop_gap", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);
    end

    // Reset while held with events queued: queue flushed, held button re-presses.
    $display("[TB] reset mid-hold");
    do_reset();
    apply_stimulus(4'b0001, 1'b0);
    cycles(22);
    check_output("pre_rst_valid", 32'(ev_valid), 32'd1);
    check_output("pre_rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_output("rst_flush_valid", 32'(ev_valid), 32'd0);
    cycle();
    check_output("rst_edge1_valid", 32'(ev_valid), 32'd0);
    cycle();
    check_output("rst_edge2_valid", 32'(ev_valid), 32'd1);
    check_output("rst_edge2_id", 32'(ev_id), 32'd0);
    check_output("rst_edge2_kind", 32'(ev_kind), 32'(P));
    expect_ev(2'd0, P);
    apply_stimulus(4'b0001, 1'b1);
    cycles(3);
    apply_stimulus(4'b0000, 1'b1);
    expect_ev(2'd0, R);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
